// File: rtl/lc_pkg.sv
// Shared types and constants for the lifecycle token checker: FSM states,
// response error codes and the highest legal lifecycle state.
package lc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_READ    = 3'd2,
        ST_WAIT    = 3'd3,
        ST_RESP    = 3'd4,
        ST_LOCKED  = 3'd5
    } lc_fsm_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_MISMATCH = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [2:0] LC_MAX_STATE = 3'd5;

endpackage

// File: rtl/lc_token_shift.sv
// Beat counter and token assembly register: beat k lands in bits
// [k*WORD +: WORD]; the counter wraps to zero after the last beat.
module lc_token_shift #(
    parameter int WIDTH = 512,
    parameter int WORD  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_beat_valid,
    input  logic [WORD-1:0]  i_beat_data,
    output logic [WIDTH-1:0] o_token,
    output logic             o_last_beat
);

    localparam int BEATS = WIDTH / WORD;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_token;
    logic             w_at_last;

    assign w_at_last   = (r_cnt == CW'(BEATS - 1));
    assign o_last_beat = i_beat_valid && w_at_last;
    assign o_token     = r_token;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_token <= '0;
        end else if (i_beat_valid) begin
            for (int k = 0; k < BEATS; k++) begin
                if (r_cnt == CW'(k)) begin
                    r_token[k*WORD +: WORD] <= i_beat_data;
                end
            end
            r_cnt <= w_at_last ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/lc_token_checker.sv
// Lifecycle transition checker: collects a multi-beat token, compares it with
// the token memory entry for the requested state and grants or denies.
module lc_token_checker
    import lc_pkg::*;
#(
    parameter int WIDTH    = 512,
    parameter int WORD     = 32,
    parameter int MAX_FAIL = 3,
    parameter int TIMEOUT  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_target,
    input  logic             tok_valid,
    output logic             tok_ready,
    input  logic [WORD-1:0]  tok_data,
    output logic             mem_rd_en,
    output logic [2:0]       mem_addr,
    input  logic [WIDTH-1:0] mem_rdData,
    input  logic             mem_valid,
    output logic             rsp_valid,
    output logic             rsp_grant,
    output logic [1:0]       rsp_err,
    output logic [2:0]       lc_state,
    output logic             locked
);

    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lc_fsm_e          r_state;
    logic [2:0]       r_target;
    logic [2:0]       r_lc_state;
    logic [FW-1:0]    r_fail;
    logic [TW-1:0]    r_wait_cnt;
    logic             r_locked;
    logic             r_mem_rd_en;
    logic [2:0]       r_mem_addr;
    logic             r_rsp_valid;
    logic             r_rsp_grant;
    logic [1:0]       r_rsp_err;

    logic             w_beat_accept;
    logic             w_last_beat;
    logic [WIDTH-1:0] w_token;
    logic             w_match;
    logic             w_illegal;
    logic [FW-1:0]    w_fail_inc;

    assign req_ready     = (r_state == ST_IDLE);
    assign tok_ready     = (r_state == ST_COLLECT);
    assign w_beat_accept = tok_valid && tok_ready;
    assign w_match       = (mem_rdData == w_token);
    assign w_illegal     = (req_target <= r_lc_state) || (req_target > LC_MAX_STATE);
    assign w_fail_inc    = (r_fail == FW'(MAX_FAIL)) ? r_fail : r_fail + FW'(1);

    assign mem_rd_en = r_mem_rd_en;
    assign mem_addr  = r_mem_addr;
    assign rsp_valid = r_rsp_valid;
    assign rsp_grant = r_rsp_grant;
    assign rsp_err   = r_rsp_err;
    assign lc_state  = r_lc_state;
    assign locked    = r_locked;

    lc_token_shift #(
        .WIDTH (WIDTH),
        .WORD  (WORD)
    ) u_shift (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_beat_valid (w_beat_accept),
        .i_beat_data  (tok_data),
        .o_token      (w_token),
        .o_last_beat  (w_last_beat)
    );

    // Response fields, lc_state and the fail counter all update on entry to
    // RESP, so RESP itself only needs to decide between IDLE and LOCKED.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_target    <= '0;
            r_lc_state  <= '0;
            r_fail      <= '0;
            r_wait_cnt  <= '0;
            r_locked    <= 1'b0;
            r_mem_rd_en <= 1'b0;
            r_mem_addr  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_grant <= 1'b0;
            r_rsp_err   <= ERR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_target <= req_target;
                        if (w_illegal) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= ERR_ILLEGAL;
                            r_state     <= ST_RESP;
                        end else begin
                            r_state <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (w_last_beat) begin
                        r_mem_rd_en <= 1'b1;
                        r_mem_addr  <= r_target;
                        r_state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    r_mem_rd_en <= 1'b0;
                    r_wait_cnt  <= '0;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                        if (w_match) begin
                            r_rsp_grant <= 1'b1;
                            r_lc_state  <= r_target;
                            r_fail      <= '0;
                        end else begin
                            r_rsp_err <= ERR_MISMATCH;
                            r_fail    <= w_fail_inc;
                        end
                    end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= ERR_TIMEOUT;
                        r_fail      <= w_fail_inc;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
                end
                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_grant <= 1'b0;
                    r_rsp_err   <= ERR_NONE;
                    if (r_fail == FW'(MAX_FAIL)) begin
                        r_locked <= 1'b1;
                        r_state  <= ST_LOCKED;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    r_locked <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc_token_checker.sv
// Randomized bench for lc_token_checker against a transaction-level model of
// lifecycle state, failure count and lock status.
module tb_lc_token_checker;

    localparam int WIDTH    = 512;
    localparam int WORD     = 32;
    localparam int MAX_FAIL = 3;
    localparam int TIMEOUT  = 4;
    localparam int BEATS    = WIDTH / WORD;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_target;
    logic             tok_valid;
    logic             tok_ready;
    logic [WORD-1:0]  tok_data;
    logic             mem_rd_en;
    logic [2:0]       mem_addr;
    logic [WIDTH-1:0] mem_rdData;
    logic             mem_valid;
    logic             rsp_valid;
    logic             rsp_grant;
    logic [1:0]       rsp_err;
    logic [2:0]       lc_state;
    logic             locked;

    always #5 clk = ~clk;

    lc_token_checker #(
        .WIDTH    (WIDTH),
        .WORD     (WORD),
        .MAX_FAIL (MAX_FAIL),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_data   (tok_data),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rdData (mem_rdData),
        .mem_valid  (mem_valid),
        .rsp_valid  (rsp_valid),
        .rsp_grant  (rsp_grant),
        .rsp_err    (rsp_err),
        .lc_state   (lc_state),
        .locked     (locked)
    );

    logic [WIDTH-1:0] mem [8];
    int checks   = 0;
    int failures = 0;
    int m_lc;
    int m_fail;
    bit m_locked;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_wide();
        logic [WIDTH-1:0] v;
        for (int k = 0; k < WIDTH / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        tok_valid  = 1'b0;
        mem_valid  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n    = 1'b1;
        m_lc     = 0;
        m_fail   = 0;
        m_locked = 1'b0;
    endtask

    // Sends whole token (unless target is illegal), plays the memory with the
    // given latency, and compares the response with the model's prediction.
    task automatic run_txn(input logic [2:0] tgt, input bit good, input int delay, input bit gappy);
        logic [WIDTH-1:0] tok;
        bit               illegal;
        bit               accept;
        bit               early;
        bit               got_rsp;
        logic             got_grant;
        logic [1:0]       got_err;
        logic [2:0]       rd_addr;
        int               rd_cnt;
        int               rd_at;
        int               quiet_bad;
        int               n_acc;
        int               cyc;
        int               flip;
        int               exp_err;
        bit               exp_grant;

        illegal   = (int'(tgt) <= m_lc) || (tgt > 3'd5);
        tok       = mem[tgt];
        flip      = $urandom_range(WIDTH - 1);
        if (!good) tok[flip] = ~tok[flip];
        early     = 1'b0;
        got_rsp   = 1'b0;
        got_grant = 1'b0;
        got_err   = 2'b00;
        rd_addr   = 3'd0;
        rd_cnt    = 0;
        rd_at     = -1;
        quiet_bad = 0;
        n_acc     = 0;

        @(negedge clk);
        check("req_ready_pre", req_ready, 1);
        req_valid  = 1'b1;
        req_target = tgt;
        @(negedge clk);
        req_valid  = 1'b0;

        if (!illegal) begin
            cyc = 0;
            while (n_acc < BEATS && cyc < 200) begin
                if (mem_rd_en || rsp_valid) early = 1'b1;
                tok_data   = tok[n_acc*WORD +: WORD];
                tok_valid  = gappy ? (cyc % 2 == 0) : 1'b1;
                mem_valid  = ($urandom_range(1) == 1);
                mem_rdData = rand_wide();
                accept     = tok_valid && tok_ready;
                @(negedge clk);
                cyc++;
                if (accept) n_acc++;
            end
            tok_valid = 1'b0;
            mem_valid = 1'b0;
            check("beats", n_acc, BEATS);
            check("early", early, 0);
        end

        cyc = 0;
        while (cyc < 40) begin
            if (mem_rd_en) begin
                rd_cnt++;
                rd_addr = mem_addr;
                rd_at   = cyc;
            end
            if (rsp_valid) begin
                got_rsp   = 1'b1;
                got_grant = rsp_grant;
                got_err   = rsp_err;
                break;
            end
            if (rsp_grant || rsp_err != 2'b00) quiet_bad++;
            mem_valid  = (rd_at >= 0) && (cyc == rd_at + delay) && (delay <= TIMEOUT);
            mem_rdData = mem_valid ? mem[rd_addr] : rand_wide();
            @(negedge clk);
            cyc++;
        end
        mem_valid = 1'b0;

        exp_grant = 1'b0;
        if (illegal) begin
            exp_err = 1;
        end else if (delay > TIMEOUT) begin
            exp_err = 3;
            m_fail  = (m_fail < MAX_FAIL) ? m_fail + 1 : MAX_FAIL;
        end else if (good) begin
            exp_err   = 0;
            exp_grant = 1'b1;
            m_lc      = int'(tgt);
            m_fail    = 0;
        end else begin
            exp_err = 2;
            m_fail  = (m_fail < MAX_FAIL) ? m_fail + 1 : MAX_FAIL;
        end
        m_locked = (m_fail == MAX_FAIL);

        check("rsp_seen", got_rsp, 1);
        check("rsp_grant", got_grant, exp_grant);
        check("rsp_err", got_err, exp_err);
        check("rd_cnt", rd_cnt, illegal ? 0 : 1);
        if (!illegal) check("rd_addr", rd_addr, tgt);
        check("quiet", quiet_bad, 0);

        @(negedge clk);
        check("rsp_pulse", rsp_valid, 0);
        check("lc_state", lc_state, m_lc);
        check("locked", locked, m_locked);
        check("req_ready_post", req_ready, !m_locked);
    endtask

    task automatic check_locked();
        int bad;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid  = 1'b1;
            req_target = 3'd5;
            tok_valid  = 1'b1;
            tok_data   = $urandom;
            if (rsp_valid || req_ready || tok_ready || !locked || mem_rd_en) bad++;
            if (int'(lc_state) != m_lc) bad++;
        end
        req_valid = 1'b0;
        tok_valid = 1'b0;
        check("locked_hold", bad, 0);
    endtask

    task automatic reset_mid_collect();
        int bad;
        @(negedge clk);
        req_valid  = 1'b1;
        req_target = 3'(m_lc + 1);
        @(negedge clk);
        req_valid  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tok_valid = 1'b1;
            tok_data  = mem[m_lc + 1][k*WORD +: WORD];
            @(negedge clk);
        end
        tok_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_async_lc", lc_state, 0);
        check("rst_async_tokrdy", tok_ready, 0);
        check("rst_async_rdy", req_ready, 1);
        check("rst_async_rsp", {rsp_valid, rsp_grant, rsp_err, mem_rd_en, mem_addr, locked}, 0);
        @(negedge clk);
        rst_n    = 1'b1;
        m_lc     = 0;
        m_fail   = 0;
        m_locked = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (rsp_valid || !req_ready || lc_state != 3'd0) bad++;
        end
        check("rst_release", bad, 0);
    endtask

    initial begin
        int  tgt;
        bit  good;
        int  delay;
        bit  gappy;

        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_target = 3'd0;
        tok_valid  = 1'b0;
        tok_data   = '0;
        mem_valid  = 1'b0;
        mem_rdData = '0;
        for (int i = 0; i < 8; i++) mem[i] = rand_wide();

        do_reset();
        @(negedge clk);
        check("reset_req_ready", req_ready, 1);
        check("reset_tok_ready", tok_ready, 0);
        check("reset_lc_state", lc_state, 0);
        check("reset_locked", locked, 0);
        check("reset_rsp", {rsp_valid, rsp_grant, rsp_err}, 0);
        check("reset_mem", {mem_rd_en, mem_addr}, 0);

        // Directed: grant, illegal targets, timeout, mismatch, then recovery.
        run_txn(3'd1, 1'b1, 2, 1'b0);
        run_txn(3'd3, 1'b1, 4, 1'b1);
        run_txn(3'd2, 1'b1, 1, 1'b0);
        run_txn(3'd3, 1'b1, 1, 1'b0);
        run_txn(3'd6, 1'b1, 1, 1'b0);
        run_txn(3'd7, 1'b1, 1, 1'b0);
        run_txn(3'd4, 1'b1, 5, 1'b0);
        run_txn(3'd4, 1'b0, 1, 1'b0);
        run_txn(3'd4, 1'b1, 3, 1'b0);

        // Three mismatches in a row lock the block.
        do_reset();
        run_txn(3'd2, 1'b1, 1, 1'b0);
        run_txn(3'd4, 1'b0, 2, 1'b0);
        run_txn(3'd4, 1'b0, 2, 1'b1);
        run_txn(3'd4, 1'b0, 3, 1'b0);
        check_locked();

        // Reset during token collection.
        do_reset();
        run_txn(3'd2, 1'b1, 1, 1'b0);
        reset_mid_collect();
        run_txn(3'd1, 1'b1, 2, 1'b1);

        for (int it = 0; it < 40; it++) begin
            if (m_locked) begin
                check_locked();
                do_reset();
            end else if (m_lc == 5) begin
                do_reset();
            end
            if ($urandom_range(9) < 7) tgt = $urandom_range(5, m_lc + 1);
            else                       tgt = $urandom_range(7);
            good  = ($urandom_range(3) != 0);
            delay = ($urandom_range(6) == 0) ? 5 + $urandom_range(2) : $urandom_range(4, 1);
            gappy = ($urandom_range(1) == 1);
            run_txn(3'(tgt), good, delay, gappy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
